// File: rtl/fp_pkg.sv
// Shared single-precision constants, field/operand types and FSM states for the FP datapath.
package fp_pkg;

  localparam int unsigned EXP_W     = 8;
  localparam int unsigned MAN_W     = 23;
  localparam int unsigned FP_W      = EXP_W + MAN_W + 1;
  localparam int unsigned SIG_W     = MAN_W + 1;
  localparam int unsigned BIAS      = 127;
  // Beyond this exponent gap every bit of Y would be shifted out anyway
  localparam int unsigned ALIGN_MAX = SIG_W + 2;

  localparam logic [EXP_W-1:0] EXP_MAX_FIN = EXP_W'(2 * BIAS);
  localparam logic [EXP_W-1:0] EXP_INF     = '1;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  localparam fp32_t CANON_NAN = '{sign: 1'b0, exp: EXP_INF, man: {1'b1, {(MAN_W-1){1'b0}}}};
  localparam fp32_t POS_INF   = '{sign: 1'b0, exp: EXP_INF, man: '0};

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } op_t;

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADDSUB, NORM, DONE} state_t;

  // Zero exponent flushes the operand; otherwise restore the hidden bit
  function automatic op_t unpack_op(input fp32_t f, input logic negate);
    op_t o;
    o.sign = f.sign ^ negate;
    o.exp  = f.exp;
    o.sig  = (f.exp == '0) ? '0 : {1'b1, f.man};
    return o;
  endfunction

endpackage

// File: rtl/fp_sub_seq_if.sv
// Request/result bundle of the sequential FP subtractor.
interface fp_sub_seq_if;
  import fp_pkg::*;

  logic             start;
  logic [FP_W-1:0]  A_FP;
  logic [FP_W-1:0]  B_FP;
  logic             busy;
  logic             done;
  logic             sign;
  logic [EXP_W-1:0] exponent;
  logic [MAN_W-1:0] mantissa;

  modport master (output start, A_FP, B_FP,
                  input  busy, done, sign, exponent, mantissa);
  modport slave  (input  start, A_FP, B_FP,
                  output busy, done, sign, exponent, mantissa);
endinterface

// File: rtl/fp_mag_cmp.sv
// Combinational magnitude compare and swap: x_c gets the larger |value| (ties keep a).
module fp_mag_cmp
  import fp_pkg::*;
(
  input  op_t a,
  input  op_t b,
  output op_t x_c,
  output op_t y_c
);
  logic b_gt;

  always_comb begin
    b_gt = {b.exp, b.sig} > {a.exp, a.sig};
    x_c  = b_gt ? b : a;
    y_c  = b_gt ? a : b;
  end
endmodule

// File: rtl/fp_sub_seq.sv
// Iterative single-precision subtractor A_FP - B_FP, one shift per cycle, truncating.
// Define FP_SPECIAL_EN for Inf/NaN handling and Inf on overflow; otherwise overflow saturates.
module fp_sub_seq
  import fp_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  fp_sub_seq_if.slave bus
);
  localparam int unsigned XE_W  = EXP_W + 1;
  localparam int unsigned ACC_W = SIG_W + 1;

  state_t           state_q, state_d;
  fp32_t            a_q, a_d, b_q, b_d;
  logic             xs_q, xs_d, ys_q, ys_d;
  logic [EXP_W-1:0] xe_q, xe_d, diff_q, diff_d;
  logic [ACC_W-1:0] xm_q, xm_d;
  logic [SIG_W-1:0] ym_q, ym_d;
  logic             busy_q, busy_d, done_q, done_d, sign_q, sign_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [MAN_W-1:0] man_q, man_d;

  op_t              op_a, op_b, x_c, y_c;
  logic [ACC_W-1:0] sum;
  logic [XE_W-1:0]  exp_inc;

  assign op_a = unpack_op(a_q, 1'b0);
  assign op_b = unpack_op(b_q, 1'b1);

  fp_mag_cmp u_cmp (.a(op_a), .b(op_b), .x_c(x_c), .y_c(y_c));

`ifdef FP_SPECIAL_EN
  logic nan_a, nan_b, inf_a, inf_b;
  assign nan_a = (a_q.exp == EXP_INF) && (a_q.man != '0);
  assign nan_b = (b_q.exp == EXP_INF) && (b_q.man != '0);
  assign inf_a = (a_q.exp == EXP_INF) && (a_q.man == '0);
  assign inf_b = (b_q.exp == EXP_INF) && (b_q.man == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      xs_q    <= 1'b0;
      ys_q    <= 1'b0;
      xe_q    <= '0;
      diff_q  <= '0;
      xm_q    <= '0;
      ym_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      man_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      xe_q    <= xe_d;
      diff_q  <= diff_d;
      xm_q    <= xm_d;
      ym_q    <= ym_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    xe_d    = xe_q;
    diff_d  = diff_q;
    xm_d    = xm_q;
    ym_d    = ym_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sign_d  = sign_q;
    exp_d   = exp_q;
    man_d   = man_q;
    // X is never smaller than Y, so the difference cannot wrap
    sum     = (xs_q == ys_q) ? xm_q + ACC_W'(ym_q) : xm_q - ACC_W'(ym_q);
    exp_inc = XE_W'(xe_q) + XE_W'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = fp32_t'(bus.A_FP);
          b_d     = fp32_t'(bus.B_FP);
          busy_d  = 1'b1;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        xs_d    = x_c.sign;
        xe_d    = x_c.exp;
        xm_d    = ACC_W'(x_c.sig);
        ys_d    = y_c.sign;
        ym_d    = y_c.sig;
        diff_d  = x_c.exp - y_c.exp;
        state_d = (x_c.exp == y_c.exp) ? ADDSUB : ALIGN;
`ifdef FP_SPECIAL_EN
        if (nan_a || nan_b || (inf_a && inf_b && (a_q.sign == b_q.sign))) begin
          xs_d    = CANON_NAN.sign;
          xe_d    = CANON_NAN.exp;
          xm_d    = ACC_W'(CANON_NAN.man);
          state_d = DONE;
        end else if (inf_a || inf_b) begin
          xs_d    = inf_a ? a_q.sign : ~b_q.sign;
          xe_d    = POS_INF.exp;
          xm_d    = ACC_W'(POS_INF.man);
          state_d = DONE;
        end
`endif
      end
      ALIGN: begin
        if (diff_q >= EXP_W'(ALIGN_MAX)) begin
          ym_d    = '0;
          diff_d  = '0;
          state_d = ADDSUB;
        end else begin
          ym_d   = ym_q >> 1;
          diff_d = diff_q - EXP_W'(1);
          if (diff_q == EXP_W'(1)) state_d = ADDSUB;
        end
      end
      ADDSUB: begin
        xm_d = sum;
        if (sum == '0) begin
          xs_d    = 1'b0;
          xe_d    = '0;
          state_d = DONE;
        end else if (sum[SIG_W] || !sum[MAN_W]) begin
          state_d = NORM;
        end else begin
          state_d = DONE;
        end
      end
      NORM: begin
        if (xm_q[SIG_W]) begin
          state_d = DONE;
          if (exp_inc >= XE_W'(EXP_INF)) begin
`ifdef FP_SPECIAL_EN
            xe_d = POS_INF.exp;
            xm_d = ACC_W'(POS_INF.man);
`else
            xe_d = EXP_MAX_FIN;
            xm_d = ACC_W'({MAN_W{1'b1}});
`endif
          end else begin
            xe_d = exp_inc[EXP_W-1:0];
            xm_d = xm_q >> 1;
          end
        end else if (xe_q == EXP_W'(1)) begin
          // Next left shift would leave the normal range: flush to +0
          xs_d    = 1'b0;
          xe_d    = '0;
          xm_d    = '0;
          state_d = DONE;
        end else begin
          xe_d = xe_q - EXP_W'(1);
          xm_d = xm_q << 1;
          if (xm_q[MAN_W-1]) state_d = DONE;
        end
      end
      DONE: begin
        sign_d  = xs_q;
        exp_d   = xe_q;
        man_d   = xm_q[MAN_W-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sign     = sign_q;
  assign bus.exponent = exp_q;
  assign bus.mantissa = man_q;

endmodule

// File: doc/fp_sub_seq.md
Name: fp_sub_seq

Overview:
- Multi-cycle IEEE-754 single-precision subtractor computing A_FP - B_FP; the inverse-direction companion to the combinational fp_add in the CNN arithmetic datapath.
- Uses an iterative FSM: one alignment shift per cycle and one normalisation shift per cycle, trading latency for area.
- Result is presented as separate sign/exponent/mantissa fields, the same output form as fp_add, so downstream consumers are shared.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa width (hidden bit excluded).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; operands sampled on the same edge.
- A_FP  in  EXP_W+MAN_W+1  minuend.
- B_FP  in  EXP_W+MAN_W+1  subtrahend.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the result is valid.
- sign  out  1  result sign.
- exponent  out  EXP_W  result biased exponent.
- mantissa  out  MAN_W  result stored mantissa.

Behaviour:
- Clocking: single clock clk; reset rst_n is asynchronous, active-low. Reset forces state IDLE and busy=0, done=0, sign=0, exponent=0, mantissa=0. Reset mid-operation aborts the operation with no done pulse.
- IDLE: start=1 captures A_FP, B_FP and moves to UNPACK. start while busy is ignored.
- UNPACK (1 cycle):
  - Invert the sign of B.
  - An operand with exponent 0 is treated as zero (denormals flushed, mantissa ignored).
  - Prepend the hidden bit to form 24-bit significands.
  - Swap operands so X holds the larger magnitude (compare exponent, then mantissa).
  - Compute diff = expX - expY.
- ALIGN: while diff>0, shift the Y significand right by 1 and decrement diff; one cycle each. If diff>=26 on entry, Y is set to 0 in a single cycle. Shifted-out bits are discarded (truncation).
- ADDSUB (1 cycle):
  - Equal signs: 25-bit add. Otherwise X-Y.
  - Result sign = sign of X.
  - Zero result forces sign=0, exp=0, mant=0 and goes to DONE.
- NORM:
  - If the carry bit (bit 24) is set: shift right 1, exp+1, one cycle.
  - Else, while bit 23=0: shift left 1, exp-1, one cycle each.
  - If exp would drop below 1, flush to +0.
  - Exponent overflow (exp reaches 255) is handled per the optional feature.
- DONE (1 cycle): register the fields, pulse done, drop busy, return to IDLE. Outputs hold until the next done or reset.
- Latency from start to done: 4 + alignment cycles + normalisation cycles. Minimum 4 (equal exponents, no normalisation).
- Rounding: truncation only.

Optional Feature:
- Macro: FP_SPECIAL_EN.
- Defined:
  - Exponent 255 inputs are Inf/NaN.
  - Any NaN input, or Inf-Inf with the same effective signs, yields canonical NaN (sign 0, exp 255, mant 0x400000).
  - An Inf operand otherwise yields a correctly signed Inf.
  - Overflow yields a signed Inf (exp 255, mant 0).
  - Special cases complete in UNPACK, then go straight to DONE (latency 3).
- Undefined:
  - Exponent 255 is an ordinary value.
  - Overflow saturates to the largest finite value (exp 254, mant 0x7FFFFF) with the computed sign.

Decomposition:
- Package fp_pkg holds:
  - EXP_W / MAN_W constants.
  - BIAS=127.
  - Canonical NaN/Inf constants.
  - An fp32 struct typedef {sign, exp, man}.
  - The FSM state enum (IDLE, UNPACK, ALIGN, ADDSUB, NORM, DONE).
- One sub-module is natural: fp_mag_cmp (combinational magnitude compare and swap), reused later by fp_add.

Test Plan:
- 7.625-0.375: A=0x40F40000, B=0x3EC00000 -> sign=0, exponent=0x81, mantissa=0x680000; done exactly 4 ALIGN cycles + 4 = 8 cycles after start.
- 65-63: A=0x42820000, B=0x427C0000 -> sign=0, exponent=0x80, mantissa=0x000000; 5 left-normalisation cycles observed.
- 3-7: A=0x40400000, B=0x40E00000 -> sign=1, exponent=0x81, mantissa=0; -6-7: A=0xC0C00000, B=0x40E00000 -> sign=1, exponent=0x82, mantissa=0x500000.
- 5-5 -> all-zero result with sign=0; A=0x40A00000 minus B=0x00000000 -> returns 0x40A00000 fields unchanged.
- Issue start during ALIGN with different operands -> ignored, first result correct; assert rst_n=0 mid-ALIGN -> outputs 0, busy=0, no done pulse.
- Largest finite minus its negative (0x7F7FFFFF - 0xFF7FFFFF) -> with FP_SPECIAL_EN: exp 255, mant 0 (+Inf); without: exp 254, mant 0x7FFFFF.
